// File: rtl/jt1942_sdram_pkg.sv
// Shared SDRAM command encodings, state enum and
// address field helpers for the download writer.
package jt1942_sdram_pkg;

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_REF = 4'b0001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACT,
    S_WR,
    S_REF,
    S_DROP,
    S_WAIT
  } state_e;

  typedef struct packed {
    logic [21:0] addr;
    logic [7:0]  data;
    logic [1:0]  mask;
  } prog_req_t;

  function automatic logic [1:0] f_bank(
    input logic [21:0] a
  );
    return a[21:20];
  endfunction

  function automatic logic [12:0] f_row(
    input logic [21:0] a
  );
    return {2'b00, a[19:9]};
  endfunction

  // A10 high selects auto-precharge on the write
  function automatic logic [12:0] f_col(
    input logic [21:0] a
  );
    return {2'b00, 1'b1, 1'b0, a[8:0]};
  endfunction

endpackage

// File: rtl/jt1942_sdram_refcnt.sv
// Free-running refresh interval counter with a
// single sticky request cleared by ref_ack_i.
module jt1942_sdram_refcnt #(
  parameter int REFCNT = 750
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ref_ack_i,
  output logic ref_req_o
);

  localparam int CW = $clog2(REFCNT);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d;
  logic          wrap;

  always_comb begin
    wrap  = (cnt_q == CW'(REFCNT - 1));
    cnt_d = wrap ? '0 : cnt_q + CW'(1);
    // a new interval wins over a same-cycle ack
    req_d = wrap | (req_q & ~ref_ack_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      req_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      req_q <= req_d;
    end
  end

  assign ref_req_o = req_q;

endmodule

// File: rtl/jt1942_prog_sdram.sv
// Download-time SDRAM writer: one-entry request buffer,
// ACTIVE/WRITE-autoprecharge sequencer and refresh.
module jt1942_prog_sdram
  import jt1942_sdram_pkg::*;
#(
  parameter int TRCD   = 2,
  parameter int TWRP   = 4,
  parameter int TRFC   = 7,
  parameter int REFCNT = 750
) (
  input  logic        clk_rom,
  input  logic        rst_n,
  input  logic        downloading,
  input  logic        prog_we,
  input  logic [21:0] prog_addr,
  input  logic [7:0]  prog_data,
  input  logic [1:0]  prog_mask,
  output logic [3:0]  sdram_cmd,
  output logic [1:0]  sdram_ba,
  output logic [12:0] sdram_a,
  output logic [15:0] sdram_dq,
  output logic        sdram_dq_oe,
  output logic [1:0]  sdram_dqm,
  output logic        prog_busy,
  output logic        prog_done,
  output logic        prog_ovf
);

  state_e      st_q, st_d, ret_q, ret_d;
  logic [3:0]  wcnt_q, wcnt_d;
  prog_req_t   buf_q, buf_d;
  logic        full_q, full_d;
  logic        we_q, ovf_q, ovf_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [1:0]  ba_q, ba_d;
  logic [12:0] a_q, a_d;
  logic [15:0] dq_q, dq_d;
  logic        oe_q, oe_d;
  logic [1:0]  dqm_q, dqm_d;
  logic        done_q, done_d;
  logic        ref_req, ref_ack;
  logic        edge_w, buf_clr;

  jt1942_sdram_refcnt #(
    .REFCNT (REFCNT)
  ) u_refcnt (
    .clk_i     (clk_rom),
    .rst_ni    (rst_n),
    .ref_ack_i (ref_ack),
    .ref_req_o (ref_req)
  );

  // request buffer
  always_comb begin
    edge_w  = prog_we & ~we_q & downloading;
    buf_clr = (st_q == S_WR) | (st_q == S_DROP);
    full_d  = full_q;
    buf_d   = buf_q;
    ovf_d   = ovf_q;
    if (buf_clr) full_d = 1'b0;
    if (edge_w) begin
      if (!full_q || buf_clr) begin
        full_d     = 1'b1;
        buf_d.addr = prog_addr;
        buf_d.data = prog_data;
        buf_d.mask = prog_mask;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_comb begin
    st_d    = st_q;
    ret_d   = ret_q;
    wcnt_d  = wcnt_q;
    cmd_d   = CMD_NOP;
    ba_d    = ba_q;
    a_d     = a_q;
    dq_d    = dq_q;
    oe_d    = 1'b0;
    dqm_d   = 2'b11;
    done_d  = 1'b0;
    ref_ack = 1'b0;
    unique case (st_q)
      S_IDLE: begin
        if (ref_req)
          st_d = S_REF;
        else if (full_q)
          st_d = (buf_q.mask == 2'b11) ? S_DROP : S_ACT;
      end
      S_ACT: begin
        cmd_d = CMD_ACT;
        ba_d  = f_bank(buf_q.addr);
        a_d   = f_row(buf_q.addr);
        if (TRCD > 1) begin
          st_d   = S_WAIT;
          wcnt_d = 4'(TRCD - 1);
          ret_d  = S_WR;
        end else begin
          st_d = S_WR;
        end
      end
      S_WR: begin
        cmd_d  = CMD_WR;
        a_d    = f_col(buf_q.addr);
        dq_d   = {buf_q.data, buf_q.data};
        oe_d   = 1'b1;
        dqm_d  = buf_q.mask;
        done_d = 1'b1;
        if (TWRP > 1) begin
          st_d   = S_WAIT;
          wcnt_d = 4'(TWRP - 1);
          ret_d  = S_IDLE;
        end else begin
          st_d = S_IDLE;
        end
      end
      S_REF: begin
        cmd_d   = CMD_REF;
        ref_ack = 1'b1;
        if (TRFC > 1) begin
          st_d   = S_WAIT;
          wcnt_d = 4'(TRFC - 1);
          ret_d  = S_IDLE;
        end else begin
          st_d = S_IDLE;
        end
      end
      S_DROP: begin
        done_d = 1'b1;
        st_d   = S_IDLE;
      end
      S_WAIT: begin
        if (wcnt_q <= 4'd1)
          st_d = ret_q;
        else
          wcnt_d = wcnt_q - 4'd1;
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= S_IDLE;
      ret_q  <= S_IDLE;
      wcnt_q <= '0;
      buf_q  <= '0;
      full_q <= 1'b0;
      we_q   <= 1'b0;
      ovf_q  <= 1'b0;
      cmd_q  <= CMD_NOP;
      ba_q   <= '0;
      a_q    <= '0;
      dq_q   <= '0;
      oe_q   <= 1'b0;
      dqm_q  <= 2'b11;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      ret_q  <= ret_d;
      wcnt_q <= wcnt_d;
      buf_q  <= buf_d;
      full_q <= full_d;
      we_q   <= prog_we;
      ovf_q  <= ovf_d;
      cmd_q  <= cmd_d;
      ba_q   <= ba_d;
      a_q    <= a_d;
      dq_q   <= dq_d;
      oe_q   <= oe_d;
      dqm_q  <= dqm_d;
      done_q <= done_d;
    end
  end

  assign sdram_cmd   = cmd_q;
  assign sdram_ba    = ba_q;
  assign sdram_a     = a_q;
  assign sdram_dq    = dq_q;
  assign sdram_dq_oe = oe_q;
  assign sdram_dqm   = dqm_q;
  assign prog_busy   = full_q | (st_q != S_IDLE);
  assign prog_done   = done_q;
  assign prog_ovf    = ovf_q;

endmodule

// File: tb/tb_jt1942_prog_sdram.sv
// Directed bench for the download SDRAM writer:
// reset, write timing, drop, overflow, refresh.
module tb_jt1942_prog_sdram;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] ACT = 4'b0011;
  localparam logic [3:0] WR  = 4'b0100;
  localparam logic [3:0] REF = 4'b0001;

  logic        clk_rom = 1'b0;
  logic        rst_n;
  logic        downloading;
  logic        prog_we;
  logic [21:0] prog_addr;
  logic [7:0]  prog_data;
  logic [1:0]  prog_mask;
  logic [3:0]  sdram_cmd;
  logic [1:0]  sdram_ba;
  logic [12:0] sdram_a;
  logic [15:0] sdram_dq;
  logic        sdram_dq_oe;
  logic [1:0]  sdram_dqm;
  logic        prog_busy;
  logic        prog_done;
  logic        prog_ovf;

  int n_chk  = 0;
  int n_pass = 0;
  int n_wr   = 0;
  int n_act  = 0;
  int n_done = 0;
  int w0, a0, d0;

  jt1942_prog_sdram dut (
    .clk_rom     (clk_rom),
    .rst_n       (rst_n),
    .downloading (downloading),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_mask   (prog_mask),
    .sdram_cmd   (sdram_cmd),
    .sdram_ba    (sdram_ba),
    .sdram_a     (sdram_a),
    .sdram_dq    (sdram_dq),
    .sdram_dq_oe (sdram_dq_oe),
    .sdram_dqm   (sdram_dqm),
    .prog_busy   (prog_busy),
    .prog_done   (prog_done),
    .prog_ovf    (prog_ovf)
  );

  always #5 clk_rom = ~clk_rom;

  always @(posedge clk_rom) begin
    if (sdram_cmd == WR)  n_wr++;
    if (sdram_cmd == ACT) n_act++;
    if (prog_done)        n_done++;
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h",
                tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_rom);
  endtask

  task automatic req(
    input logic [21:0] a,
    input logic [7:0]  d,
    input logic [1:0]  m
  );
    prog_addr = a;
    prog_data = d;
    prog_mask = m;
    prog_we   = 1'b1;
  endtask

  task automatic do_reset();
    tick(1);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n       = 1'b0;
    downloading = 1'b1;
    prog_we     = 1'b0;
    prog_addr   = '0;
    prog_data   = '0;
    prog_mask   = '0;
    tick(1);
    chk("rst_cmd", 32'(sdram_cmd), 32'(NOP));
    chk("rst_ba", 32'(sdram_ba), 0);
    chk("rst_a", 32'(sdram_a), 0);
    chk("rst_dq", 32'(sdram_dq), 0);
    chk("rst_oe", 32'(sdram_dq_oe), 0);
    chk("rst_dqm", 32'(sdram_dqm), 3);
    chk("rst_busy", 32'(prog_busy), 0);
    chk("rst_done", 32'(prog_done), 0);
    chk("rst_ovf", 32'(prog_ovf), 0);
    rst_n = 1'b1;

    // reset while the WRITE command is on the bus
    req(22'h30_0010, 8'hC3, 2'b00);
    tick(1);
    prog_we = 1'b0;
    tick(4);
    chk("t1_wr", 32'(sdram_cmd), 32'(WR));
    rst_n = 1'b0;
    #1;
    chk("t1_cmd", 32'(sdram_cmd), 32'(NOP));
    chk("t1_dqm", 32'(sdram_dqm), 3);
    chk("t1_busy", 32'(prog_busy), 0);
    chk("t1_oe", 32'(sdram_dq_oe), 0);
    tick(1);
    rst_n = 1'b1;

    // idle write
    req(22'h20_0A03, 8'h5A, 2'b01);
    tick(1);
    chk("t2_busy", 32'(prog_busy), 1);
    prog_we = 1'b0;
    tick(2);
    chk("t2_act", 32'(sdram_cmd), 32'(ACT));
    chk("t2_ba", 32'(sdram_ba), 2);
    chk("t2_row", 32'(sdram_a), 32'h005);
    tick(1);
    chk("t2_nop", 32'(sdram_cmd), 32'(NOP));
    tick(1);
    chk("t2_wr", 32'(sdram_cmd), 32'(WR));
    chk("t2_col", 32'(sdram_a), 32'h403);
    chk("t2_dq", 32'(sdram_dq), 32'h5A5A);
    chk("t2_dqm", 32'(sdram_dqm), 1);
    chk("t2_oe", 32'(sdram_dq_oe), 1);
    chk("t2_done", 32'(prog_done), 1);
    tick(1);
    chk("t2_done0", 32'(prog_done), 0);
    chk("t2_oe0", 32'(sdram_dq_oe), 0);
    chk("t2_dqm3", 32'(sdram_dqm), 3);
    tick(5);
    chk("t2_idle", 32'(prog_busy), 0);

    // masked PROM drop
    w0 = n_wr;
    a0 = n_act;
    req(22'h3F_FFFF, 8'hAA, 2'b11);
    tick(1);
    chk("t3_busy", 32'(prog_busy), 1);
    prog_we = 1'b0;
    tick(1);
    chk("t3_done_e", 32'(prog_done), 0);
    tick(1);
    chk("t3_done", 32'(prog_done), 1);
    chk("t3_busy0", 32'(prog_busy), 0);
    tick(6);
    chk("t3_no_act", n_act - a0, 0);
    chk("t3_no_wr", n_wr - w0, 0);

    // overflow: A written, B buffered, C dropped
    w0 = n_wr;
    req(22'h01_0203, 8'h11, 2'b00);
    tick(1);
    prog_we = 1'b0;
    tick(3);
    req(22'h02_0405, 8'h22, 2'b10);
    tick(1);
    chk("t5_wr_a", 32'(sdram_cmd), 32'(WR));
    chk("t5_dq_a", 32'(sdram_dq), 32'h1111);
    chk("t5_col_a", 32'(sdram_a), 32'h403);
    chk("t5_ovf0", 32'(prog_ovf), 0);
    prog_we = 1'b0;
    tick(1);
    req(22'h03_0607, 8'h33, 2'b01);
    tick(1);
    chk("t5_ovf1", 32'(prog_ovf), 1);
    prog_we = 1'b0;
    tick(5);
    chk("t5_wr_b", 32'(sdram_cmd), 32'(WR));
    chk("t5_dq_b", 32'(sdram_dq), 32'h2222);
    chk("t5_dqm_b", 32'(sdram_dqm), 2);
    chk("t5_col_b", 32'(sdram_a), 32'h405);
    tick(15);
    chk("t5_nwr", n_wr - w0, 2);
    chk("t5_sticky", 32'(prog_ovf), 1);

    // held prog_we, then edge with downloading low
    do_reset();
    chk("t6_ovf_clr", 32'(prog_ovf), 0);
    w0 = n_wr;
    d0 = n_done;
    req(22'h00_0100, 8'h44, 2'b00);
    tick(10);
    prog_we = 1'b0;
    tick(15);
    chk("t6_nwr", n_wr - w0, 1);
    chk("t6_ndone", n_done - d0, 1);
    downloading = 1'b0;
    w0 = n_wr;
    a0 = n_act;
    d0 = n_done;
    req(22'h00_0200, 8'h55, 2'b00);
    tick(3);
    prog_we = 1'b0;
    tick(10);
    chk("t6_off_wr", n_wr - w0, 0);
    chk("t6_off_act", n_act - a0, 0);
    chk("t6_off_done", n_done - d0, 0);
    chk("t6_off_busy", 32'(prog_busy), 0);

    // request edge on the same cycle ref_req rises
    downloading = 1'b1;
    do_reset();
    tick(749);
    req(22'h10_0601, 8'h77, 2'b00);
    tick(1);
    prog_we = 1'b0;
    tick(2);
    chk("t4_ref", 32'(sdram_cmd), 32'(REF));
    chk("t4_busy", 32'(prog_busy), 1);
    tick(8);
    chk("t4_act", 32'(sdram_cmd), 32'(ACT));
    chk("t4_ba", 32'(sdram_ba), 1);
    chk("t4_row", 32'(sdram_a), 32'h003);
    tick(2);
    chk("t4_wr", 32'(sdram_cmd), 32'(WR));
    chk("t4_col", 32'(sdram_a), 32'h401);
    chk("t4_dq", 32'(sdram_dq), 32'h7777);
    chk("t4_done", 32'(prog_done), 1);
    downloading = 1'b0;
    tick(740);
    chk("t4_ref2", 32'(sdram_cmd), 32'(REF));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
